// File: rtl/fifo_control_pkg.sv
// fifo_control_pkg: shared FIFO geometry so the memory, controller and bench agree
package fifo_control_pkg;
  localparam int FIFO_MEM_SIZE = 8;
  localparam int FIFO_WORD_SIZE = 10;
  localparam int FIFO_PTR = 3;
endpackage

// File: rtl/ptr_counter.sv
// ptr_counter: wrap-around pointer with enable and async reset
module ptr_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/fifo_control.sv
// fifo_control: pointer/flag controller for the dual-pointer FIFO memory
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int MEM_SIZE = FIFO_MEM_SIZE,
  parameter int WORD_SIZE = FIFO_WORD_SIZE,
  parameter int PTR = FIFO_PTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_req,
  input  logic                 pop_req,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [PTR:0]         umbral_alto,
  input  logic [PTR:0]         umbral_bajo,
  input  logic [WORD_SIZE-1:0] data_out_MM,
  output logic                 push,
  output logic                 pop,
  output logic [PTR-1:0]       wr_ptr,
  output logic [PTR-1:0]       rd_ptr,
  output logic [WORD_SIZE-1:0] data_in_MM,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [PTR:0]         count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);
  always_comb begin
    full = count == (PTR+1)'(MEM_SIZE);
    empty = count == '0;
    almost_full = count >= umbral_alto;
    almost_empty = count <= umbral_bajo;
    push = push_req & ~full & ~reset;
    pop = pop_req & ~empty & ~reset;
    data_in_MM = data_in;
    data_out = data_out_MM;
  end
  ptr_counter #(.W(PTR)) u_wr (.clk(clk), .reset(reset), .en(push), .q(wr_ptr));
  ptr_counter #(.W(PTR)) u_rd (.clk(clk), .reset(reset), .en(pop), .q(rd_ptr));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      valid_out <= 1'b0;
      error <= 1'b0;
    end else begin
      count <= count + (PTR+1)'(push) - (PTR+1)'(pop);
      valid_out <= pop;
      error <= error | (push_req & full) | (pop_req & empty);
    end
endmodule

// File: tb/tb_fifo_control.sv
// tb_fifo_control: vector table plus directed corner sequences, with a memory model
module tb_fifo_control;
  logic clk = 0, reset = 1, push_req = 0, pop_req = 0;
  logic [9:0] data_in = '0, data_out_MM, data_in_MM, data_out;
  logic [3:0] umbral_alto = 4'd6, umbral_bajo = 4'd2, count;
  logic push, pop, valid_out, full, empty, almost_full, almost_empty, error;
  logic [2:0] wr_ptr, rd_ptr;
  logic [9:0] mem [8];
  int checks = 0, errors = 0;
  logic [9:0] q[$];
  logic [9:0] nxt = 10'd1;
  logic exp_valid = 0;

  typedef struct {
    logic pr, pp;
    logic [3:0] cnt;
    logic fu, em, af, ae, er, ep, eo;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fifo_control dut (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req), .data_in(data_in),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .data_out_MM(data_out_MM),
    .push(push), .pop(pop), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .data_in_MM(data_in_MM),
    .data_out(data_out), .valid_out(valid_out), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
  );

  always @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in_MM;
    if (pop) data_out_MM <= mem[rd_ptr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic pr, input logic pp, input logic ep, input logic eo);
    @(negedge clk);
    chk("valid_out", valid_out, exp_valid);
    if (exp_valid) chk("data_out", data_out, q.pop_front());
    push_req = pr;
    pop_req = pp;
    data_in = nxt;
    #1;
    chk("push", push, ep);
    chk("pop", pop, eo);
    chk("data_in_MM", data_in_MM, nxt);
    if (ep) begin
      q.push_back(nxt);
      nxt++;
    end
    exp_valid = eo;
  endtask

  function automatic vec_t v(input logic pr, pp, input int c, input logic fu, em, af, ae, er, ep, eo);
    v = '{pr, pp, 4'(c), fu, em, af, ae, er, ep, eo};
  endfunction

  initial begin
    tbl.push_back(v(1,0, 0, 0,1,0,1, 0, 1,0));
    tbl.push_back(v(1,0, 1, 0,0,0,1, 0, 1,0));
    tbl.push_back(v(1,0, 2, 0,0,0,1, 0, 1,0));
    tbl.push_back(v(1,0, 3, 0,0,0,0, 0, 1,0));
    tbl.push_back(v(1,0, 4, 0,0,0,0, 0, 1,0));
    tbl.push_back(v(1,0, 5, 0,0,0,0, 0, 1,0));
    tbl.push_back(v(1,0, 6, 0,0,1,0, 0, 1,0));
    tbl.push_back(v(1,0, 7, 0,0,1,0, 0, 1,0));
    tbl.push_back(v(1,0, 8, 1,0,1,0, 0, 0,0));
    tbl.push_back(v(0,0, 8, 1,0,1,0, 1, 0,0));
    tbl.push_back(v(0,1, 8, 1,0,1,0, 1, 0,1));
    tbl.push_back(v(0,1, 7, 0,0,1,0, 1, 0,1));
    tbl.push_back(v(0,1, 6, 0,0,1,0, 1, 0,1));
    tbl.push_back(v(0,1, 5, 0,0,0,0, 1, 0,1));
    tbl.push_back(v(0,1, 4, 0,0,0,0, 1, 0,1));
    tbl.push_back(v(0,1, 3, 0,0,0,0, 1, 0,1));
    tbl.push_back(v(0,1, 2, 0,0,0,1, 1, 0,1));
    tbl.push_back(v(0,1, 1, 0,0,0,1, 1, 0,1));
    tbl.push_back(v(0,1, 0, 0,1,0,1, 1, 0,0));
    tbl.push_back(v(1,1, 0, 0,1,0,1, 1, 1,0));
    tbl.push_back(v(0,0, 1, 0,0,0,1, 1, 0,0));

    umbral_alto = 4'd0;
    #2;
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst almost_full alto0", almost_full, 1);
    umbral_alto = 4'd6;
    #1 chk("rst almost_full alto6", almost_full, 0);
    chk("rst valid_out", valid_out, 0);
    chk("rst error", error, 0);
    @(negedge clk) reset = 0;

    foreach (tbl[i]) begin
      cyc(tbl[i].pr, tbl[i].pp, tbl[i].ep, tbl[i].eo);
      chk($sformatf("count[%0d]", i), count, tbl[i].cnt);
      chk($sformatf("full[%0d]", i), full, tbl[i].fu);
      chk($sformatf("empty[%0d]", i), empty, tbl[i].em);
      chk($sformatf("almost_full[%0d]", i), almost_full, tbl[i].af);
      chk($sformatf("almost_empty[%0d]", i), almost_empty, tbl[i].ae);
      chk($sformatf("error[%0d]", i), error, tbl[i].er);
      if (i == 9) chk("wr_ptr wrap", wr_ptr, 0);
      if (i == 19) chk("rd_ptr wrap", rd_ptr, 0);
    end
    chk("wr_ptr after empty push", wr_ptr, 1);

    repeat (4) cyc(1, 0, 1, 0);
    @(negedge clk);
    chk("pre-reset count", count, 5);
    push_req = 1;
    pop_req = 1;
    reset = 1;
    #1;
    chk("mid rst count", count, 0);
    chk("mid rst empty", empty, 1);
    chk("mid rst almost_empty", almost_empty, 1);
    chk("mid rst wr_ptr", wr_ptr, 0);
    chk("mid rst rd_ptr", rd_ptr, 0);
    chk("mid rst error", error, 0);
    chk("mid rst push", push, 0);
    chk("mid rst pop", pop, 0);
    @(negedge clk);
    chk("held rst count", count, 0);
    push_req = 0;
    pop_req = 0;
    reset = 0;
    q.delete();
    exp_valid = 0;

    repeat (4) cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("c4 count", count, 4);
    chk("c4 almost_full alto6", almost_full, 0);
    umbral_alto = 4'd3;
    #1 chk("c4 almost_full alto3", almost_full, 1);
    umbral_alto = 4'd6;
    repeat (10) cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);
    chk("simul count", count, 4);
    chk("simul wr_ptr", wr_ptr, 6);
    chk("simul rd_ptr", rd_ptr, 2);
    chk("simul error", error, 0);

    repeat (4) cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("fill count", count, 8);
    chk("fill full", full, 1);
    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    chk("full simul count", count, 7);
    chk("full simul error", error, 1);
    repeat (7) cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    chk("drain count", count, 0);
    chk("drain empty", empty, 1);
    chk("drain queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
